// File: rtl/mprj_wb_watchdog.sv
// Wishbone bridge from the management core to the user project with a bus
// watchdog. A downstream cycle that is not acked within TIMEOUT cycles is
// completed upstream with ERR_DATA, and the event is logged in sticky status.
module mprj_wb_watchdog #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        mprj_cyc_o,
    output logic        mprj_stb_o,
    output logic        mprj_we_o,
    output logic [3:0]  mprj_sel_o,
    output logic [31:0] mprj_adr_o,
    output logic [31:0] mprj_dat_o,
    input  logic        mprj_ack_i,
    input  logic [31:0] mprj_dat_i,
    input  logic        mprj_wb_iena,
    input  logic        to_clr,
    output logic        to_flag,
    output logic [7:0]  to_count,
    output logic [31:0] to_adr
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state;
    logic [CntW-1:0] wait_cnt;
    logic            valid_ack;
    logic [7:0]      count_base;
    logic [7:0]      count_inc;

    // A user ack only counts while the user-return path is enabled.
    always_comb begin
        valid_ack = mprj_ack_i & mprj_wb_iena;
    end

    // Timeout count seen by a timeout this cycle; a coinciding clear restarts it from zero.
    always_comb begin
        count_base = to_clr ? 8'd0 : to_count;
        count_inc  = (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
    end

    // Bridge FSM, wait counter, registered bus outputs and timeout status.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= StIdle;
            wait_cnt   <= '0;
            m_ack_o    <= 1'b0;
            m_dat_o    <= '0;
            mprj_cyc_o <= 1'b0;
            mprj_stb_o <= 1'b0;
            mprj_we_o  <= 1'b0;
            mprj_sel_o <= '0;
            mprj_adr_o <= '0;
            mprj_dat_o <= '0;
            to_flag    <= 1'b0;
            to_count   <= '0;
            to_adr     <= '0;
        end else begin
            m_ack_o <= 1'b0;
            if (to_clr) begin
                to_flag  <= 1'b0;
                to_count <= '0;
                to_adr   <= '0;
            end
            unique case (state)
                StIdle: begin
                    // Ack cycle is excluded so a strobe still held by the master is not re-captured.
                    if (m_cyc_i && m_stb_i && !m_ack_o) begin
                        mprj_we_o  <= m_we_i;
                        mprj_sel_o <= m_sel_i;
                        mprj_adr_o <= m_adr_i;
                        mprj_dat_o <= m_dat_i;
                        mprj_cyc_o <= 1'b1;
                        mprj_stb_o <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= StBusy;
                    end
                end
                StBusy: begin
                    if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CntW'(1);
                    end
                    if (!m_cyc_i) begin
                        // Master abandoned the cycle: drop quietly.
                        mprj_cyc_o <= 1'b0;
                        mprj_stb_o <= 1'b0;
                        state      <= StIdle;
                    end else if (valid_ack) begin
                        m_ack_o    <= 1'b1;
                        m_dat_o    <= mprj_dat_i;
                        mprj_cyc_o <= 1'b0;
                        mprj_stb_o <= 1'b0;
                        state      <= StIdle;
                    end else if (wait_cnt == CntLast) begin
                        m_ack_o    <= 1'b1;
                        m_dat_o    <= ERR_DATA;
                        mprj_cyc_o <= 1'b0;
                        mprj_stb_o <= 1'b0;
                        to_flag    <= 1'b1;
                        to_count   <= count_inc;
                        to_adr     <= mprj_adr_o;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_wb_watchdog.sv
// Directed bench for mprj_wb_watchdog with TIMEOUT=8. "Cycle N" is the clock
// period after N rising edges from the start of a scenario; inputs are set
// and outputs sampled 1 time unit after each rising edge.
module tb_mprj_wb_watchdog;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic        m_ack;
    logic [31:0] m_rdat;
    logic        p_cyc, p_stb, p_we;
    logic [3:0]  p_sel;
    logic [31:0] p_adr, p_dat;
    logic        p_ack;
    logic [31:0] p_rdat;
    logic        iena, clr;
    logic        flag;
    logic [7:0]  count;
    logic [31:0] tadr;

    int checks = 0;
    int errors = 0;

    mprj_wb_watchdog #(
        .TIMEOUT (8),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .m_cyc_i     (m_cyc),
        .m_stb_i     (m_stb),
        .m_we_i      (m_we),
        .m_sel_i     (m_sel),
        .m_adr_i     (m_adr),
        .m_dat_i     (m_dat),
        .m_ack_o     (m_ack),
        .m_dat_o     (m_rdat),
        .mprj_cyc_o  (p_cyc),
        .mprj_stb_o  (p_stb),
        .mprj_we_o   (p_we),
        .mprj_sel_o  (p_sel),
        .mprj_adr_o  (p_adr),
        .mprj_dat_o  (p_dat),
        .mprj_ack_i  (p_ack),
        .mprj_dat_i  (p_rdat),
        .mprj_wb_iena(iena),
        .to_clr      (clr),
        .to_flag     (flag),
        .to_count    (count),
        .to_adr      (tadr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we  = we;
        m_adr = adr;
        m_dat = dat;
        m_sel = sel;
    endtask

    task automatic end_req();
        m_cyc = 1'b0;
        m_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({m_ack, m_rdat, p_cyc, p_stb, p_we, p_sel, p_adr, p_dat} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got ack=%b dat=%h stb=%b adr=%h expected all zero",
                     m_ack, m_rdat, p_stb, p_adr);
        end
        checks++;
        if ({flag, count, tadr} !== '0) begin
            errors++;
            $display("FAIL reset_status: got flag=%b count=%0d adr=%h expected 0/0/0",
                     flag, count, tadr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        start_req(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (p_stb !== 1'b1 || p_cyc !== 1'b1 || m_ack !== 1'b0) begin
                errors++;
                $display("FAIL read_stb_c%0d: got stb=%b cyc=%b ack=%b expected 1/1/0",
                         c, p_stb, p_cyc, m_ack);
            end
            if (c == 3) begin
                p_ack  = 1'b1;
                p_rdat = 32'h1234_5678;
            end
        end
        tick();  // cycle 4; master keeps strobe up through the ack edge
        p_ack = 1'b0;
        checks++;
        if (m_ack !== 1'b1 || m_rdat !== 32'h1234_5678 || p_stb !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: got ack=%b dat=%h stb=%b expected 1/12345678/0",
                     m_ack, m_rdat, p_stb);
        end
        tick();  // cycle 5: held strobe must not be re-captured, data holds
        end_req();
        checks++;
        if (m_ack !== 1'b0 || p_stb !== 1'b0 || m_rdat !== 32'h1234_5678 || flag !== 1'b0) begin
            errors++;
            $display("FAIL read_after: got ack=%b stb=%b dat=%h flag=%b expected 0/0/12345678/0",
                     m_ack, p_stb, m_rdat, flag);
        end
        tick();
    endtask

    task automatic test_write();
        start_req(1'b1, 32'h3000_0008, 32'hA5A5_0001, 4'h3);
        tick();
        checks++;
        if (p_stb !== 1'b1 || p_we !== 1'b1 || p_sel !== 4'h3 || p_adr !== 32'h3000_0008 ||
            p_dat !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL write_fields: got stb=%b we=%b sel=%h adr=%h dat=%h expected 1/1/3/30000008/a5a50001",
                     p_stb, p_we, p_sel, p_adr, p_dat);
        end
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0;
        end_req();
        checks++;
        if (m_ack !== 1'b1 || p_stb !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: got ack=%b stb=%b expected 1/0", m_ack, p_stb);
        end
        tick();
        checks++;
        if (m_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse: got ack=%b expected 0", m_ack);
        end
    endtask

    task automatic test_timeout();
        start_req(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (p_stb !== 1'b1 || m_ack !== 1'b0) begin
                errors++;
                $display("FAIL timeout_stb_c%0d: got stb=%b ack=%b expected 1/0", c, p_stb, m_ack);
            end
        end
        tick();  // cycle 9
        end_req();
        checks++;
        if (m_ack !== 1'b1 || m_rdat !== 32'hDEAD_BEEF || p_stb !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack: got ack=%b dat=%h stb=%b expected 1/deadbeef/0",
                     m_ack, m_rdat, p_stb);
        end
        checks++;
        if (flag !== 1'b1 || count !== 8'd1 || tadr !== 32'h3000_0010) begin
            errors++;
            $display("FAIL timeout_status: got flag=%b count=%0d adr=%h expected 1/1/30000010",
                     flag, count, tadr);
        end
        tick();
        checks++;
        if (m_ack !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got ack=%b expected 0", m_ack);
        end
    endtask

    task automatic test_gated_ack();
        start_req(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            tick();
            p_ack  = (c == 2);
            iena   = (c != 2);
            p_rdat = 32'h5555_AAAA;
        end
        tick();  // cycle 9
        end_req();
        checks++;
        if (m_ack !== 1'b1 || m_rdat !== 32'hDEAD_BEEF || count !== 8'd2 ||
            tadr !== 32'h3000_0020) begin
            errors++;
            $display("FAIL gated_timeout: got ack=%b dat=%h count=%0d adr=%h expected 1/deadbeef/2/30000020",
                     m_ack, m_rdat, count, tadr);
        end
        tick();  // cycle 10: late ack while idle
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0;
        checks++;
        if (m_ack !== 1'b0 || p_stb !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: got ack=%b stb=%b expected 0/0", m_ack, p_stb);
        end
        tick();
    endtask

    task automatic test_ack_at_limit();
        start_req(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 8) begin
                p_ack  = 1'b1;
                p_rdat = 32'hCAFE_0008;
            end
        end
        tick();  // cycle 9
        p_ack = 1'b0;
        end_req();
        checks++;
        if (m_ack !== 1'b1 || m_rdat !== 32'hCAFE_0008) begin
            errors++;
            $display("FAIL limit_ack: got ack=%b dat=%h expected 1/cafe0008", m_ack, m_rdat);
        end
        checks++;
        if (flag !== 1'b1 || count !== 8'd2 || tadr !== 32'h3000_0020) begin
            errors++;
            $display("FAIL limit_status: got flag=%b count=%0d adr=%h expected 1/2/30000020",
                     flag, count, tadr);
        end
        tick();
    endtask

    task automatic test_abort();
        start_req(1'b0, 32'h3000_0034, 32'h0, 4'hF);
        for (int c = 1; c <= 4; c++) tick();
        end_req();  // cycle 4
        checks++;
        if (p_stb !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got stb=%b expected 1", p_stb);
        end
        tick();  // cycle 5
        checks++;
        if (p_stb !== 1'b0 || p_cyc !== 1'b0 || m_ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: got stb=%b cyc=%b ack=%b expected 0/0/0", p_stb, p_cyc, m_ack);
        end
        for (int c = 6; c <= 12; c++) begin
            tick();
            checks++;
            if (m_ack !== 1'b0 || count !== 8'd2) begin
                errors++;
                $display("FAIL abort_quiet_c%0d: got ack=%b count=%0d expected 0/2", c, m_ack, count);
            end
        end
    endtask

    task automatic test_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (flag !== 1'b0 || count !== 8'd0 || tadr !== 32'h0) begin
            errors++;
            $display("FAIL clear: got flag=%b count=%0d adr=%h expected 0/0/0", flag, count, tadr);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        start_req(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        for (int c = 1; c <= 3000; c++) begin
            tick();
            if (m_ack === 1'b1) acks++;
        end
        end_req();
        checks++;
        if (acks != 300) begin
            errors++;
            $display("FAIL b2b_acks: got %0d expected 300", acks);
        end
        checks++;
        if (count !== 8'd255 || tadr !== 32'h3000_0040) begin
            errors++;
            $display("FAIL b2b_saturate: got count=%0d adr=%h expected 255/30000040", count, tadr);
        end
        tick();
        tick();
    endtask

    task automatic test_clear_vs_timeout();
        start_req(1'b0, 32'h3000_0044, 32'h0, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            tick();
            clr = (c == 8);
        end
        tick();  // cycle 9
        clr = 1'b0;
        end_req();
        checks++;
        if (m_ack !== 1'b1 || flag !== 1'b1 || count !== 8'd1 || tadr !== 32'h3000_0044) begin
            errors++;
            $display("FAIL clr_timeout: got ack=%b flag=%b count=%0d adr=%h expected 1/1/1/30000044",
                     m_ack, flag, count, tadr);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_req(1'b1, 32'h3000_0050, 32'h7777_0000, 4'h5);
        for (int c = 1; c <= 3; c++) tick();
        rst = 1'b1;  // cycle 3
        tick();      // cycle 4
        rst = 1'b0;
        end_req();
        checks++;
        if ({m_ack, m_rdat, p_cyc, p_stb, p_we, p_sel, p_adr, p_dat} !== '0 ||
            {flag, count, tadr} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got ack=%b dat=%h stb=%b adr=%h flag=%b count=%0d expected all zero",
                     m_ack, m_rdat, p_stb, p_adr, flag, count);
        end
        for (int c = 5; c <= 14; c++) begin
            tick();
            checks++;
            if (m_ack !== 1'b0 || flag !== 1'b0 || p_stb !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet_c%0d: got ack=%b flag=%b stb=%b expected 0/0/0",
                         c, m_ack, flag, p_stb);
            end
        end
    endtask

    task automatic test_fresh_after_reset();
        start_req(1'b0, 32'h3000_0060, 32'h0, 4'hF);
        tick();
        p_ack  = 1'b1;
        p_rdat = 32'h0BAD_F00D;
        checks++;
        if (p_stb !== 1'b1 || p_adr !== 32'h3000_0060) begin
            errors++;
            $display("FAIL fresh_req: got stb=%b adr=%h expected 1/30000060", p_stb, p_adr);
        end
        tick();
        p_ack = 1'b0;
        end_req();
        checks++;
        if (m_ack !== 1'b1 || m_rdat !== 32'h0BAD_F00D || flag !== 1'b0) begin
            errors++;
            $display("FAIL fresh_ack: got ack=%b dat=%h flag=%b expected 1/0badf00d/0",
                     m_ack, m_rdat, flag);
        end
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        m_cyc  = 1'b0;
        m_stb  = 1'b0;
        m_we   = 1'b0;
        m_sel  = 4'h0;
        m_adr  = 32'h0;
        m_dat  = 32'h0;
        p_ack  = 1'b0;
        p_rdat = 32'h0;
        iena   = 1'b1;
        clr    = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_gated_ack();
        test_ack_at_limit();
        test_abort();
        test_clear();
        test_back_to_back();
        test_clear_vs_timeout();
        test_reset_mid();
        test_fresh_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
